// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts a latched WIDTH-bit pattern out MSB-first on a registered
// output for repeat+1 frames, with optional zero gaps, and counts the rising edges it emits.
module seq_pattern_tx #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned CNT_W      = 4,
  parameter int unsigned GAP_CYCLES = 1,
  parameter int unsigned EC_W       = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] pattern_i,
  input  logic [CNT_W-1:0] repeat_i,
  input  logic             abort_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             w_o,
  output logic             done_o,
  output logic [EC_W-1:0]  edge_cnt_o
);

  localparam int unsigned BitW = $clog2(WIDTH);
  localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [BitW-1:0] BitLoad = BitW'(WIDTH - 1);
  localparam logic [GapW-1:0] GapLoad = (GAP_CYCLES > 0) ? GapW'(GAP_CYCLES - 1) : '0;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
  localparam logic [1:0] StGap   = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BitW-1:0]  bit_q, bit_d;
  logic [CNT_W-1:0] frames_q, frames_d;
  logic [GapW-1:0]  gap_q, gap_d;
  logic             w_q, w_d;
  logic             done_q, done_d;
  logic [EC_W-1:0]  edge_q, edge_d;
  logic             accept;
  logic [EC_W-1:0]  edge_base;

  always_comb begin
    state_d  = state_q;
    pat_d    = pat_q;
    shreg_d  = shreg_q;
    bit_d    = bit_q;
    frames_d = frames_q;
    gap_d    = gap_q;
    w_d      = 1'b0;
    done_d   = 1'b0;
    accept   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          accept   = 1'b1;
          pat_d    = pattern_i;
          frames_d = repeat_i;
          w_d      = pattern_i[WIDTH-1];
          shreg_d  = {pattern_i[WIDTH-2:0], 1'b0};
          bit_d    = BitLoad;
          state_d  = StShift;
        end
      end
      StShift: begin
        // bit_q counts the bits still to follow the one currently on w
        if (bit_q != '0) begin
          w_d     = shreg_q[WIDTH-1];
          shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
          bit_d   = bit_q - 1'b1;
        end else if (frames_q == '0) begin
          done_d  = 1'b1;
          state_d = StDone;
        end else begin
          frames_d = frames_q - 1'b1;
          if (GAP_CYCLES > 0) begin
            gap_d   = GapLoad;
            state_d = StGap;
          end else begin
            w_d     = pat_q[WIDTH-1];
            shreg_d = {pat_q[WIDTH-2:0], 1'b0};
            bit_d   = BitLoad;
          end
        end
      end
      StGap: begin
        if (gap_q == '0) begin
          w_d     = pat_q[WIDTH-1];
          shreg_d = {pat_q[WIDTH-2:0], 1'b0};
          bit_d   = BitLoad;
          state_d = StShift;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Abort beats every other transition; start still wins in IDLE
    if (abort_i && (state_q != StIdle)) begin
      state_d = StIdle;
      w_d     = 1'b0;
      done_d  = 1'b0;
    end
  end

  // w_q is always 0 in IDLE, so a leading 1 at accept registers as a rise
  always_comb begin
    edge_base = accept ? '0 : edge_q;
    edge_d    = edge_base;
    if (w_d && !w_q && (edge_base != {EC_W{1'b1}})) begin
      edge_d = edge_base + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      pat_q    <= '0;
      shreg_q  <= '0;
      bit_q    <= '0;
      frames_q <= '0;
      gap_q    <= '0;
      w_q      <= 1'b0;
      done_q   <= 1'b0;
      edge_q   <= '0;
    end else begin
      state_q  <= state_d;
      pat_q    <= pat_d;
      shreg_q  <= shreg_d;
      bit_q    <= bit_d;
      frames_q <= frames_d;
      gap_q    <= gap_d;
      w_q      <= w_d;
      done_q   <= done_d;
      edge_q   <= edge_d;
    end
  end

  assign ready_o    = (state_q == StIdle);
  assign busy_o     = (state_q == StShift) || (state_q == StGap);
  assign w_o        = w_q;
  assign done_o     = done_q;
  assign edge_cnt_o = edge_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: two instances (gap of 2 with 8-bit edge count, no gap with 4-bit
// edge count) driven in parallel and compared cycle by cycle with a bit-stream model.
module tb_seq_pattern_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic [7:0] pattern;
  logic [3:0] rep;

  logic       ready_a, busy_a, w_a, done_a;
  logic [7:0] ec_a;
  logic       ready_b, busy_b, w_b, done_b;
  logic [3:0] ec_b;

  int n_chk  = 0;
  int n_fail = 0;

  typedef bit bitq_t[$];

  always #5 clk = ~clk;

  seq_pattern_tx #(.WIDTH(8), .CNT_W(4), .GAP_CYCLES(2), .EC_W(8)) dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start), .pattern_i(pattern), .repeat_i(rep),
    .abort_i(abort), .ready_o(ready_a), .busy_o(busy_a), .w_o(w_a), .done_o(done_a),
    .edge_cnt_o(ec_a)
  );

  seq_pattern_tx #(.WIDTH(8), .CNT_W(4), .GAP_CYCLES(0), .EC_W(4)) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start), .pattern_i(pattern), .repeat_i(rep),
    .abort_i(abort), .ready_o(ready_b), .busy_o(busy_b), .w_o(w_b), .done_o(done_b),
    .edge_cnt_o(ec_b)
  );

  // Full serial stream the transmitter should emit for one transaction
  function automatic bitq_t expand(logic [7:0] p, int r, int gap);
    bitq_t q;
    for (int f = 0; f <= r; f++) begin
      for (int b = 7; b >= 0; b--) q.push_back(p[b]);
      if (f < r) for (int g = 0; g < gap; g++) q.push_back(1'b0);
    end
    return q;
  endfunction

  function automatic int rises(bitq_t q, int upto, int maxv);
    int n = 0;
    bit prev = 1'b0;
    for (int i = 0; i < upto; i++) begin
      if (q[i] && !prev) n++;
      prev = q[i];
    end
    return (n > maxv) ? maxv : n;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_dut(string name, int i, bitq_t q, int eff, bit aborted, int maxv,
                           logic w, logic rdy, logic bsy, logic dn, logic [31:0] ec);
    logic       ew, erdy, ebsy, edn;
    logic [31:0] eec;
    if (i < eff) begin
      ew = q[i]; ebsy = 1'b1; erdy = 1'b0; edn = 1'b0; eec = rises(q, i + 1, maxv);
    end else if (i == eff && !aborted) begin
      ew = 1'b0; ebsy = 1'b0; erdy = 1'b0; edn = 1'b1; eec = rises(q, eff, maxv);
    end else begin
      ew = 1'b0; ebsy = 1'b0; erdy = 1'b1; edn = 1'b0; eec = rises(q, eff, maxv);
    end
    chk($sformatf("%s.w[%0d]", name, i), {31'b0, w}, {31'b0, ew});
    chk($sformatf("%s.ready[%0d]", name, i), {31'b0, rdy}, {31'b0, erdy});
    chk($sformatf("%s.busy[%0d]", name, i), {31'b0, bsy}, {31'b0, ebsy});
    chk($sformatf("%s.done[%0d]", name, i), {31'b0, dn}, {31'b0, edn});
    chk($sformatf("%s.edge_cnt[%0d]", name, i), ec, eec);
  endtask

  task automatic check_reset(string tag);
    chk({tag, ".a.w"}, {31'b0, w_a}, 32'd0);
    chk({tag, ".a.ready"}, {31'b0, ready_a}, 32'd1);
    chk({tag, ".a.busy"}, {31'b0, busy_a}, 32'd0);
    chk({tag, ".a.done"}, {31'b0, done_a}, 32'd0);
    chk({tag, ".a.edge_cnt"}, {24'b0, ec_a}, 32'd0);
    chk({tag, ".b.w"}, {31'b0, w_b}, 32'd0);
    chk({tag, ".b.ready"}, {31'b0, ready_b}, 32'd1);
    chk({tag, ".b.edge_cnt"}, {28'b0, ec_b}, 32'd0);
  endtask

  // abort_idx / ign_idx / rst_idx index the cycle after accept (0 = first bit); -1 disables
  task automatic run_txn(logic [7:0] p, int r, int abort_idx, int ign_idx, int rst_idx,
                         bit with_abort);
    bitq_t qa, qb;
    int effa, effb, na, nb, n;
    bit aba, abb;
    @(negedge clk);
    start = 1'b1; pattern = p; rep = 4'(r); abort = with_abort;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0; pattern = 8'($urandom); rep = 4'($urandom);
    qa = expand(p, r, 2);
    qb = expand(p, r, 0);
    aba = (abort_idx >= 0) && (abort_idx < qa.size());
    abb = (abort_idx >= 0) && (abort_idx < qb.size());
    effa = aba ? abort_idx + 1 : qa.size();
    effb = abb ? abort_idx + 1 : qb.size();
    na = effa + (aba ? 1 : 2);
    nb = effb + (abb ? 1 : 2);
    n = (na > nb) ? na : nb;
    for (int i = 0; i < n; i++) begin
      if (i == rst_idx) begin
        #2 rst = 1'b1;
        #1 check_reset("midreset");
        @(negedge clk) rst = 1'b0;
        return;
      end
      check_dut("a", i, qa, effa, aba, 255, w_a, ready_a, busy_a, done_a, {24'b0, ec_a});
      check_dut("b", i, qb, effb, abb, 15, w_b, ready_b, busy_b, done_b, {28'b0, ec_b});
      start = (i == ign_idx);
      if (i == ign_idx) pattern = 8'h00;
      abort = (i == abort_idx);
      if (i < n - 1) begin
        @(posedge clk); #1;
      end
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    int r, ab, ig, len_b;
    rst = 1'b1; start = 1'b0; abort = 1'b0; pattern = '0; rep = '0;
    repeat (2) @(posedge clk);
    #1 check_reset("reset");
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1 check_reset("post_reset");

    run_txn(8'hB6, 0, -1, -1, -1, 1'b0);  // single frame, edge_cnt 3
    run_txn(8'hB6, 2, -1, -1, -1, 1'b0);  // three frames with gaps
    run_txn(8'hFF, 1, -1, -1, -1, 1'b0);  // all ones, back-to-back on b
    run_txn(8'hB6, 0, -1, 2, -1, 1'b0);   // start while busy is ignored
    run_txn(8'hB6, 0, 3, -1, -1, 1'b0);   // abort after four bits
    run_txn(8'hB6, 0, -1, -1, -1, 1'b0);  // restart right after abort
    run_txn(8'hB6, 0, -1, -1, 4, 1'b0);   // async reset mid-frame
    run_txn(8'hB6, 0, -1, -1, -1, 1'b0);
    run_txn(8'h5A, 1, -1, -1, -1, 1'b1);  // start with abort in IDLE
    run_txn(8'hAA, 15, -1, -1, -1, 1'b0); // 16 frames, edge count saturates on b
    run_txn(8'h00, 0, -1, -1, -1, 1'b0);

    for (int t = 0; t < 25; t++) begin
      r = $urandom_range(0, 3);
      len_b = 8 * (r + 1);
      ab = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 8 * (r + 1) + 2 * r) : -1;
      ig = -1;
      if ($urandom_range(0, 1) == 1) begin
        ig = $urandom_range(0, len_b - 1);
        if (ab >= 0 && ig > ab) ig = ab;
      end
      run_txn(8'($urandom), r, ab, ig, -1, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
